// File: rtl/avalon_hex_display_if.sv
// Avalon-MM slave bus bundle for avalon_hex_display (word address, zero-wait reads).
interface avalon_hex_display_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_hex_display.sv
// Avalon-MM register block driving NUM_DIGITS seven-segment digits with hex decode, blink and blank.
// Optional decimal point per digit when HEX_DISP_DP_EN is defined (SW=8, else SW=7).
module avalon_hex_display #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1,
`ifdef HEX_DISP_DP_EN
  localparam int SW = 8
`else
  localparam int SW = 7
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  avalon_hex_display_if.slave      bus,
  output logic [NUM_DIGITS*SW-1:0] out_port
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] INV = {SW{ACTIVE_LOW != 0}};

  typedef enum logic [3:0] {
    REG_CTRL   = 4'd8,
    REG_MASK   = 4'd9,
    REG_PACKED = 4'd10,
    REG_STATUS = 4'd11
  } reg_addr_e;

  logic [SW-1:0]           digit [NUM_DIGITS];
  logic                    decode;
  logic                    blank;
  logic                    blink_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [CW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [NUM_DIGITS*SW-1:0] out_next;
  logic                    wr;
  logic                    ctrl_wr;
  logic                    unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign ctrl_wr      = wr && (bus.address == REG_CTRL);
  assign unused_wdata = ^bus.writedata;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [SW-1:0] lit_pattern(input logic [SW-1:0] d, input logic dec);
    logic [6:0] seg;
    seg = dec ? hex_seg(d[3:0]) : d[6:0];
`ifdef HEX_DISP_DP_EN
    return {d[7], seg};
`else
    return seg;
`endif
  endfunction

  always_comb begin
    out_next = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (blank || (blink_en && blink_mask[i] && blink_phase))
        out_next[SW*i +: SW] = INV;
      else
        out_next[SW*i +: SW] = lit_pattern(digit[i], decode) ^ INV;
    end
  end

  always_comb begin
    bus.readdata = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bus.address == 4'(i))
        bus.readdata[SW-1:0] = digit[i];
    end
    case (bus.address)
      REG_CTRL:   bus.readdata[2:0] = {blink_en, blank, decode};
      REG_MASK:   bus.readdata[NUM_DIGITS-1:0] = blink_mask;
      REG_STATUS: bus.readdata[0] = blink_phase;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        digit[i] <= '0;
      decode      <= 1'b0;
      blank       <= 1'b0;
      blink_en    <= 1'b0;
      blink_mask  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      out_port    <= {NUM_DIGITS{INV}};
    end else begin
      out_port <= out_next;

      if (wr) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (bus.address == 4'(i))
            digit[i] <= bus.writedata[SW-1:0];
          if (bus.address == REG_PACKED)
            digit[i] <= SW'(bus.writedata[4*i +: 4]);
        end
        if (bus.address == REG_CTRL)
          {blink_en, blank, decode} <= bus.writedata[2:0];
        if (bus.address == REG_MASK)
          blink_mask <= bus.writedata[NUM_DIGITS-1:0];
      end

      // A CTRL write overrides a coincident wrap: disabling clears, enabling from off restarts;
      // rewriting with BLINK_EN already set leaves the engine running.
      if (ctrl_wr && !(bus.writedata[2] && blink_en)) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_en) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/avalon_hex_display.md
Name: avalon_hex_display

Overview:
Parametrised Avalon-MM slave driving NUM_DIGITS seven-segment digits from one register block, replacing one PIO per digit. Each digit is raw-segment or hex-decoded (global mode), with per-digit blink and a global blank. Sits on the Nios II system bus; out_port goes to the board HEX pins.

Parameters:
NUM_DIGITS, 6, number of digits (1..8)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)
ACTIVE_LOW, 1, 1 = segment lit by driving 0 (DE-series boards); 0 = lit by 1

Ports:
clk  in  1  system clock
reset_n  in  1  async active-low reset
address  in  4  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address
out_port  out  NUM_DIGITS*SW  segment outputs; digit i at [SW*i+SW-1 : SW*i]; SW=7, or 8 with HEX_DISP_DP_EN

Behaviour:
- Interface: reset_n asynchronous, active-low; clock clk. All state on posedge clk, cleared on negedge reset_n.
- Write accepted when chipselect && !write_n at a rising edge; reads zero-wait, no side effects.
- Register map (unlisted bits read 0, writes ignored):
  - 0..NUM_DIGITS-1 DIGIT[i]: bits[6:0] raw segments (bit0=a .. bit6=g, 1=lit); decode mode uses bits[3:0]. Addresses NUM_DIGITS..7 read 0, writes ignored.
  - 8 CTRL: bit0 DECODE, bit1 BLANK, bit2 BLINK_EN.
  - 9 BLINK_MASK: bits[NUM_DIGITS-1:0].
  - 10 PACKED (write-only, reads 0): nibble i of writedata -> DIGIT[i][3:0] for all i in one write; DIGIT[i][6:4] cleared.
  - 11 STATUS (read-only): bit0 blink_phase.
  - 12..15: read 0, writes ignored.
- Hex decode (DECODE=1), nibble -> seg[6:0] active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Blink engine: counter 0..BLINK_DIV-1 runs while BLINK_EN=1; on wrap to 0 blink_phase toggles. BLINK_EN=0: counter and phase held at 0. A CTRL write taking BLINK_EN 0->1 starts from count 0, phase 0.
- Digit i lit pattern = 0 if BLANK, or if BLINK_EN && BLINK_MASK[i] && blink_phase; else decoded/raw value.
- out_port registered: lit pattern, XOR-inverted when ACTIVE_LOW=1. Write at edge k -> register updated at k -> out_port at edge k+1 (1-cycle latency). Blink phase change -> out_port next edge.
- Reset: all registers, counter, phase = 0; out_port = all ones (ACTIVE_LOW=1) or all zeros (ACTIVE_LOW=0), i.e. all dark; readdata per map = 0.
- Reset asserted mid-blink or mid-write: everything returns to reset state immediately; pending write lost.
- Simultaneous events: CTRL write and counter wrap in same cycle: write wins (BLINK_EN cleared -> phase 0; re-enabled -> restart). PACKED and DIGIT writes cannot coincide (single address).

Optional Feature:
HEX_DISP_DP_EN
- Defined: SW=8; DIGIT[i] bit7 is decimal point, passed through in both modes, blanked/blinked/inverted with its digit; bit7 read back; PACKED write clears bit7.
- Undefined: SW=7; bit7 not stored, reads 0, out_port width NUM_DIGITS*7.

Test Plan:
- Reset: reset_n low mid-run, NUM_DIGITS=6, ACTIVE_LOW=1 -> out_port = 42'h3FF_FFFF_FFFF immediately, all readdata 0.
- Raw write: DIGIT[2]=0x5B at edge k -> readdata(addr2)=0x5B after k; out_port[20:14]=~0x5B=0x24 at k+1, other digits 0x7F.
- Decode + packed: CTRL=0x1, PACKED=0x00A5F3 -> digits 0..5 show 3,F,5,A,0,0 = ~{4F,71,6D,77,3F,3F}; addr2 reads 0x5.
- Blink, BLINK_DIV=4: BLINK_MASK=0x01, CTRL=0x5, DIGIT[0]=0x8 -> digit0 alternates 0x00 (lit) and 0x7F every 4 cycles, STATUS toggles; digit1 steady; CTRL=0x1 -> steady, phase 0.
- Blank + edges: CTRL=0x3 -> all 0x7F; write addr 7 and 13 -> no change, read 0; CTRL=0x1 restores.
- HEX_DISP_DP_EN build: DIGIT[0]=0x86, DECODE=0 -> out_port[7:0]=0x79; readback 0x86.
